// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one combinational instruction ROM read port between
// CPU fetch (port 0, fixed priority) and a debug/trace reader (port 1).
// A streak counter caps how many consecutive port-0 grants port 1 can wait.
// Read data is registered and returned one cycle after the grant.
// Ports:
//   clk, reset (async, active-high)
//   p0_req/p0_addr/p0_gnt/p0_rvalid/p0_rdata: fetch port
//   p1_req/p1_addr/p1_gnt/p1_rvalid/p1_rdata: debug port
//   mem_a/mem_rd: byte address to and combinational data from the ROM
// Optional macro IMEM_ARB_ALIGN_CHECK_EN adds p0_err/p1_err and flags
// misaligned addresses (response rdata forced to 0, mem_a word-aligned).
module imem_arbiter #(
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic [AW-1:0] p1_addr,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
`ifdef IMEM_ARB_ALIGN_CHECK_EN
  output logic          p0_err,
  output logic          p1_err,
`endif
  output logic [AW-1:0] mem_a,
  input  logic [DW-1:0] mem_rd
);

  localparam int unsigned SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          gnt0, gnt1;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] rdata_d;
  logic          p0_rvalid_q, p1_rvalid_q;
  logic [DW-1:0] p0_rdata_q, p1_rdata_q;

  // Port 0 wins conflicts until port 1 has waited MAX_STREAK grants.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (p0_req && p1_req) begin
        if (streak_q == STREAK_MAX) gnt1 = 1'b1;
        else                        gnt0 = 1'b1;
      end else if (p0_req) begin
        gnt0 = 1'b1;
      end else if (p1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    addr_sel = '0;
    if (gnt0)      addr_sel = p0_addr;
    else if (gnt1) addr_sel = p1_addr;
  end

  // Streak only counts while port 1 is actually waiting.
  always_comb begin
    streak_d = streak_q;
    if (!p1_req || gnt1)
      streak_d = '0;
    else if (gnt0 && streak_q != STREAK_MAX)
      streak_d = streak_q + SW'(1);
  end

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  logic misalign;
  logic p0_err_q, p1_err_q;

  assign misalign = |addr_sel[1:0];
  assign mem_a    = {addr_sel[AW-1:2], 2'b00};
  assign rdata_d  = misalign ? '0 : mem_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_err_q <= 1'b0;
      p1_err_q <= 1'b0;
    end else begin
      p0_err_q <= gnt0 & misalign;
      p1_err_q <= gnt1 & misalign;
    end
  end

  assign p0_err = p0_err_q;
  assign p1_err = p1_err_q;
`else
  assign mem_a   = addr_sel;
  assign rdata_d = mem_rd;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q    <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      streak_q    <= streak_d;
      p0_rvalid_q <= gnt0;
      p1_rvalid_q <= gnt1;
      if (gnt0) p0_rdata_q <= rdata_d;
      if (gnt1) p1_rdata_q <= rdata_d;
    end
  end

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed self-checking bench for imem_arbiter.
// Drives inputs #1 after posedge, checks grants before the next edge.
module tb_imem_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p1_req;
  logic [31:0] p0_addr, p1_addr;
  logic        p0_gnt, p1_gnt;
  logic        p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_a, mem_rd;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
  logic        p0_err, p1_err;
`endif

  logic [31:0] rom [16];
  logic [3:0]  widx;

  int n_tests = 0;
  int n_fail  = 0;

  assign widx   = mem_a[5:2];
  assign mem_rd = rom[widx];

  imem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .p0_req    (p0_req),
    .p0_addr   (p0_addr),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_addr   (p1_addr),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    .p0_err    (p0_err),
    .p1_err    (p1_err),
`endif
    .mem_a     (mem_a),
    .mem_rd    (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sexp [3];
    logic [9:0]  pat;
    logic [8:0]  p1v;
    logic [8:0]  win;

    for (int i = 0; i < 16; i++) rom[i] = 32'hA5A5_0000 | i;
    rom[2] = 32'hDEAD_BEEF;
    sexp[0] = 32'hA5A5_0000;
    sexp[1] = 32'hA5A5_0001;
    sexp[2] = 32'hDEAD_BEEF;

    // reset state, request present during reset
    reset   = 1'b1;
    p0_req  = 1'b1;
    p1_req  = 1'b1;
    p0_addr = 32'h8;
    p1_addr = 32'hC;
    #2;
    chk("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
    chk("rst_p1_gnt", {31'd0, p1_gnt}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
    chk("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    chk("rst_p1_rdata", p1_rdata, 32'd0);
    cyc();
    reset  = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    p0_addr = 32'h20;
    p1_addr = 32'h24;
    #1;
    chk("idle_mem_a", mem_a, 32'd0);
    chk("idle_p0_gnt", {31'd0, p0_gnt}, 32'd0);
    chk("idle_p1_gnt", {31'd0, p1_gnt}, 32'd0);
    cyc();

    // single p0 read
    p0_req  = 1'b1;
    p0_addr = 32'h8;
    #1;
    chk("single_gnt", {31'd0, p0_gnt}, 32'd1);
    chk("single_p1_gnt", {31'd0, p1_gnt}, 32'd0);
    chk("single_mem_a", mem_a, 32'h8);
    cyc();
    chk("single_rvalid", {31'd0, p0_rvalid}, 32'd1);
    chk("single_rdata", p0_rdata, 32'hDEAD_BEEF);
    chk("single_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    p0_req = 1'b0;
    cyc();
    chk("single_rvalid_drop", {31'd0, p0_rvalid}, 32'd0);

    // streaming reads 0x0, 0x4, 0x8
    p0_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p0_addr = 32'(i * 4);
      #1;
      chk($sformatf("stream_gnt%0d", i), {31'd0, p0_gnt}, 32'd1);
      cyc();
      chk($sformatf("stream_rvalid%0d", i), {31'd0, p0_rvalid}, 32'd1);
      chk($sformatf("stream_rdata%0d", i), p0_rdata, sexp[i]);
    end
    p0_req = 1'b0;
    cyc();
    chk("stream_end_rvalid", {31'd0, p0_rvalid}, 32'd0);

    // starvation bound: bit i set means port 1 wins cycle i
    pat     = 10'b10_0001_0000;
    p0_addr = 32'h10;
    p1_addr = 32'h14;
    p0_req  = 1'b1;
    p1_req  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("starve_p1g%0d", i), {31'd0, p1_gnt}, {31'd0, pat[i]});
      chk($sformatf("starve_p0g%0d", i), {31'd0, p0_gnt}, {31'd0, ~pat[i]});
      cyc();
      if (pat[i]) begin
        chk($sformatf("starve_p1rv%0d", i), {31'd0, p1_rvalid}, 32'd1);
        chk($sformatf("starve_p1rd%0d", i), p1_rdata, 32'hA5A5_0005);
        chk($sformatf("starve_p0rv%0d", i), {31'd0, p0_rvalid}, 32'd0);
      end else begin
        chk($sformatf("starve_p0rv%0d", i), {31'd0, p0_rvalid}, 32'd1);
        chk($sformatf("starve_p0rd%0d", i), p0_rdata, 32'hA5A5_0004);
        chk($sformatf("starve_p1rv%0d", i), {31'd0, p1_rvalid}, 32'd0);
      end
    end

    // streak clear: p1_req low for one cycle after three p0 grants
    p1v = 9'b1_1111_0111;
    win = 9'b1_0000_0000;
    for (int i = 0; i < 9; i++) begin
      p1_req = p1v[i];
      #1;
      chk($sformatf("clr_p1g%0d", i), {31'd0, p1_gnt}, {31'd0, win[i]});
      chk($sformatf("clr_p0g%0d", i), {31'd0, p0_gnt}, {31'd0, ~win[i]});
      cyc();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    cyc();

    // async reset with a p1 response in flight
    p1_req  = 1'b1;
    p1_addr = 32'h1C;
    #1;
    chk("ar_p1_gnt", {31'd0, p1_gnt}, 32'd1);
    cyc();
    chk("ar_p1_rvalid", {31'd0, p1_rvalid}, 32'd1);
    chk("ar_p1_rdata", p1_rdata, 32'hA5A5_0007);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_rvalid_now", {31'd0, p1_rvalid}, 32'd0);
    chk("ar_gnt_now", {31'd0, p1_gnt}, 32'd0);
    chk("ar_mem_a_now", mem_a, 32'd0);
    chk("ar_rdata_now", p1_rdata, 32'd0);
    cyc();
    reset  = 1'b0;
    p1_req = 1'b0;
    chk("ar_rvalid_rel", {31'd0, p1_rvalid}, 32'd0);
    cyc();
    chk("ar_rvalid_post", {31'd0, p1_rvalid}, 32'd0);
    p0_req  = 1'b1;
    p1_req  = 1'b1;
    p0_addr = 32'h0;
    #1;
    chk("ar_first_p0", {31'd0, p0_gnt}, 32'd1);
    chk("ar_first_p1", {31'd0, p1_gnt}, 32'd0);
    cyc();
    p0_req = 1'b0;
    p1_req = 1'b0;
    cyc();

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    p1_req  = 1'b1;
    p1_addr = 32'h6;
    #1;
    chk("al_p1_gnt", {31'd0, p1_gnt}, 32'd1);
    chk("al_mem_a", mem_a, 32'h4);
    cyc();
    p1_req = 1'b0;
    chk("al_rvalid", {31'd0, p1_rvalid}, 32'd1);
    chk("al_err", {31'd0, p1_err}, 32'd1);
    chk("al_rdata", p1_rdata, 32'd0);
    chk("al_p0_err", {31'd0, p0_err}, 32'd0);
    cyc();
    chk("al_err_clr", {31'd0, p1_err}, 32'd0);
`else
    p0_req  = 1'b1;
    p0_addr = 32'h6;
    #1;
    chk("na_mem_a", mem_a, 32'h6);
    cyc();
    p0_req = 1'b0;
    chk("na_rdata", p0_rdata, 32'hA5A5_0001);
    cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
